// File: rtl/mac_job_sequencer_if.sv
// Signal bundle between the MAC job sequencer and its job source, operand
// memory, MAC engine and result consumer.
interface mac_job_sequencer_if #(
    parameter int AW = 8
) ();
    logic          job_valid;
    logic          job_ready;
    logic [1:0]    job_mode;
    logic [7:0]    job_len;
    logic [AW-1:0] job_addr;

    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_act;
    logic [7:0]    mem_wgt;

    logic [7:0]    mac_act;
    logic [7:0]    mac_wgt;
    logic [1:0]    mac_mode;
    logic          mac_en;
    logic [7:0]    mac_batch;
    logic          mac_valid;
    logic          mac_ready;
    logic [127:0]  mac_obuf;

    logic          res_valid;
    logic          res_ready;
    logic [127:0]  res_data;
    logic [1:0]    res_mode;
    logic          res_err;

    // Sequencer side.
    modport slave (
        input  job_valid, job_mode, job_len, job_addr,
        input  mem_act, mem_wgt, mac_valid, mac_obuf, res_ready,
        output job_ready, mem_rd_en, mem_rd_addr,
        output mac_act, mac_wgt, mac_mode, mac_en, mac_batch, mac_ready,
        output res_valid, res_data, res_mode, res_err
    );

    // Environment side (job source, memory, engine, result sink).
    modport master (
        output job_valid, job_mode, job_len, job_addr,
        output mem_act, mem_wgt, mac_valid, mac_obuf, res_ready,
        input  job_ready, mem_rd_en, mem_rd_addr,
        input  mac_act, mac_wgt, mac_mode, mac_en, mac_batch, mac_ready,
        input  res_valid, res_data, res_mode, res_err
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// Accepts a MAC job, streams its operand pairs from memory into the MAC engine,
// waits (bounded) for the engine result and presents it on the result port.
module mac_job_sequencer #(
    parameter int TIMEOUT = 1023,
    parameter int AW      = 8
) (
    input  logic                clk,
    input  logic                nrst,
    mac_job_sequencer_if.slave  bus,
    output logic                o_busy,
    output logic [15:0]         o_job_count
);
    localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_mode;
    logic [7:0]     r_len;
    logic [7:0]     r_idx;
    logic [AW-1:0]  r_rd_addr;
    logic           r_rd_d;
    logic [WW-1:0]  r_wait;
    logic [127:0]   r_res_data;
    logic           r_res_err;
    logic [15:0]    r_job_count;

    logic w_illegal;
    logic w_accept;
    logic w_rd_en;
    logic w_mac_en;
    logic w_mac_ready;
    logic w_res_valid;
    logic w_res_hs;
    logic w_timeout;

    assign w_illegal = (bus.job_len == 8'd0) || (bus.job_mode == 2'b11);
    assign w_timeout = (r_wait == WW'(TIMEOUT - 1));

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_rd_en     = 1'b0;
        w_mac_en    = 1'b0;
        w_mac_ready = 1'b0;
        w_res_valid = 1'b0;
        w_res_hs    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.job_valid;
                if (bus.job_valid) w_next = w_illegal ? S_RESP : S_STREAM;
            end
            S_STREAM: begin
                w_rd_en  = 1'b1;
                w_mac_en = 1'b1;
                if (r_idx == r_len - 8'd1) w_next = S_WAIT;
            end
            S_WAIT: begin
                w_mac_en    = 1'b1;
                w_mac_ready = 1'b1;
                if (bus.mac_valid || w_timeout) w_next = S_RESP;
            end
            S_RESP: begin
                w_res_valid = 1'b1;
                w_res_hs    = bus.res_ready;
                if (bus.res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: reset is synchronous and clears the result register too, so res_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_mode      <= 2'b00;
            r_len       <= 8'd0;
            r_idx       <= 8'd0;
            r_rd_addr   <= '0;
            r_rd_d      <= 1'b0;
            r_wait      <= '0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_job_count <= 16'd0;
        end else begin
            r_rd_d <= w_rd_en;
            if (w_accept) begin
                r_mode    <= bus.job_mode;
                r_len     <= bus.job_len;
                r_rd_addr <= bus.job_addr;
                r_idx     <= 8'd0;
                if (w_illegal) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end
            end
            if (r_state == S_STREAM) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                r_idx     <= r_idx + 8'd1;
                r_wait    <= '0;
            end
            // mac_valid is only honoured in WAIT and beats a same-cycle timeout.
            if (r_state == S_WAIT) begin
                r_wait <= r_wait + 1'b1;
                if (bus.mac_valid) begin
                    r_res_data <= bus.mac_obuf;
                    r_res_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end
            end
            if (w_res_hs && (r_job_count != 16'hFFFF)) r_job_count <= r_job_count + 16'd1;
        end
    end

    assign bus.job_ready   = (r_state == S_IDLE);
    assign bus.mem_rd_en   = w_rd_en;
    assign bus.mem_rd_addr = r_rd_addr;
    assign bus.mac_act     = r_rd_d ? bus.mem_act : 8'd0;
    assign bus.mac_wgt     = r_rd_d ? bus.mem_wgt : 8'd0;
    assign bus.mac_mode    = r_mode;
    assign bus.mac_batch   = r_len;
    assign bus.mac_en      = w_mac_en;
    assign bus.mac_ready   = w_mac_ready;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_data    = r_res_data;
    assign bus.res_mode    = r_mode;
    assign bus.res_err     = r_res_err;
    assign o_busy          = (r_state != S_IDLE);
    assign o_job_count     = r_job_count;
endmodule

// File: tb/tb_mac_job_sequencer.sv
// Randomized self-checking bench: a cycle-level job timeline derived from the
// block's rules predicts every output and is compared at the falling edge.
module tb_mac_job_sequencer;
    localparam int TIMEOUT = 8;
    localparam int AW      = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        busy;
    logic [15:0] job_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;

    logic [7:0] mem_a [256];
    logic [7:0] mem_w [256];

    mac_job_sequencer_if #(.AW(AW)) bus ();

    mac_job_sequencer #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .bus         (bus),
        .o_busy      (busy),
        .o_job_count (job_count)
    );

    always #5 clk = ~clk;

    // Operand memory: data one cycle after a read, random junk otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_act <= mem_a[bus.mem_rd_addr];
            bus.mem_wgt <= mem_w[bus.mem_rd_addr];
        end else begin
            bus.mem_act <= 8'($urandom);
            bus.mem_wgt <= 8'($urandom);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_job_ready"}, bus.job_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_mac_en"}, bus.mac_en, 0);
        check({tag, "_res_valid"}, bus.res_valid, 0);
        check({tag, "_count"}, job_count, exp_count);
    endtask

    // delay: WAIT-cycle index at which the engine answers (>= TIMEOUT or <0 means never).
    task automatic run_job(input logic [1:0] mode, input int len, input logic [7:0] addr,
                           input int delay, input logic [127:0] obuf, input int hold);
        bit          illegal;
        bit          hit;
        logic [7:0]  a;
        logic [7:0]  prev;
        logic [127:0] exp_data;
        illegal = (len == 0) || (mode == 2'b11);
        hit = 1'b0;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 8'($urandom);
            mem_w[k] = 8'($urandom);
        end
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_mode  = mode;
        bus.job_len   = len[7:0];
        bus.job_addr  = addr;
        check("pre_job_ready", bus.job_ready, 1);
        @(negedge clk);
        bus.job_valid = 1'b0;
        bus.job_mode  = 2'($urandom);
        bus.job_len   = 8'($urandom);
        if (!illegal) begin
            for (int i = 0; i < len; i++) begin
                a = addr + i[7:0];
                prev = a - 8'd1;
                check("stream_rd_en", bus.mem_rd_en, 1);
                check("stream_rd_addr", bus.mem_rd_addr, a);
                check("stream_mac_en", bus.mac_en, 1);
                check("stream_mac_ready", bus.mac_ready, 0);
                check("stream_job_ready", bus.job_ready, 0);
                check("stream_batch", bus.mac_batch, len);
                check("stream_mode", bus.mac_mode, mode);
                check("stream_act", bus.mac_act, (i == 0) ? 8'd0 : mem_a[prev]);
                check("stream_wgt", bus.mac_wgt, (i == 0) ? 8'd0 : mem_w[prev]);
                bus.mac_valid = 1'($urandom);
                bus.mac_obuf  = {4{32'($urandom)}};
                @(negedge clk);
            end
            for (int w = 0; w < TIMEOUT; w++) begin
                a = addr + len[7:0] - 8'd1;
                check("wait_rd_en", bus.mem_rd_en, 0);
                check("wait_mac_en", bus.mac_en, 1);
                check("wait_mac_ready", bus.mac_ready, 1);
                check("wait_res_valid", bus.res_valid, 0);
                check("wait_act", bus.mac_act, (w == 0) ? mem_a[a] : 8'd0);
                check("wait_wgt", bus.mac_wgt, (w == 0) ? mem_w[a] : 8'd0);
                hit = (w == delay);
                bus.mac_valid = hit;
                bus.mac_obuf  = hit ? obuf : {4{32'($urandom)}};
                @(negedge clk);
                bus.mac_valid = 1'b0;
                if (hit) break;
            end
        end
        exp_data = hit ? obuf : 128'd0;
        for (int h = 0; h <= hold; h++) begin
            check("resp_valid", bus.res_valid, 1);
            check("resp_data", bus.res_data, exp_data);
            check("resp_err", bus.res_err, !hit);
            check("resp_mode", bus.res_mode, mode);
            check("resp_job_ready", bus.job_ready, 0);
            check("resp_mac_en", bus.mac_en, 0);
            check("resp_rd_en", bus.mem_rd_en, 0);
            if (h == hold) begin
                bus.res_ready = 1'b1;
                bus.job_valid = 1'b1;  // must not be taken in the handshake cycle
                bus.job_mode  = 2'b10;
                bus.job_len   = 8'd1;
            end
            @(negedge clk);
        end
        bus.res_ready = 1'b0;
        bus.job_valid = 1'b0;
        if (exp_count != 16'hFFFF) exp_count++;
        check_idle("post");
    endtask

    initial begin
        bus.job_valid = 1'b0;
        bus.job_mode  = 2'b00;
        bus.job_len   = 8'd0;
        bus.job_addr  = '0;
        bus.mac_valid = 1'b0;
        bus.mac_obuf  = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_res_data", bus.res_data, 0);
        check("reset_res_err", bus.res_err, 0);
        check("reset_mac_batch", bus.mac_batch, 0);
        nrst = 1'b1;

        // Reset during STREAM at i=2 of a len=6 job.
        @(negedge clk);
        bus.job_valid = 1'b1;
        bus.job_mode  = 2'b01;
        bus.job_len   = 8'd6;
        bus.job_addr  = 8'h40;
        @(negedge clk);
        bus.job_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_rd_addr", bus.mem_rd_addr, 8'h42);
        nrst = 1'b0;
        @(negedge clk);
        check_idle("abort");
        nrst = 1'b1;

        run_job(2'b10, 4, 8'h10, 3, 128'h1234, 0);
        check("basic_count", job_count, 1);
        run_job(2'b00, 3, 8'hFE, 1, 128'hABCD_0000_5555, 0);
        run_job(2'b01, 0, 8'h22, 0, 128'h1, 1);
        run_job(2'b11, 5, 8'h33, 0, 128'h1, 0);
        run_job(2'b10, 2, 8'h50, -1, 128'h77, 0);
        run_job(2'b01, 1, 8'h60, 0, 128'hDEAD_BEEF, 5);
        run_job(2'b00, 3, 8'h70, TIMEOUT - 1, 128'hF00D, 2);

        for (int n = 0; n < 30; n++) begin
            run_job(2'($urandom), int'($urandom_range(0, 10)), 8'($urandom),
                    int'($urandom_range(0, TIMEOUT + 2)) - 1,
                    {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
                    int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
